// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants, width helper and FSM states for the CIC interpolator
package cic_pkg;

  localparam int CIC_N   = 3;
  localparam int CIC_R   = 16;
  localparam int CIC_WIN = 16;

  typedef enum logic {IDLE, RUN} cic_state_t;

  // Bit growth of an N-stage interpolator at ratio R beyond the input width
  function automatic int cic_guard_bits(input int n, input int r);
    return (n - 1) * $clog2(r);
  endfunction

endpackage

// File: rtl/cic_int_stage.sv
// rtl/cic_int_stage.sv - one wrap-around integrator stage of the CIC interpolator
module cic_int_stage #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  // Accumulate modulo 2^W while enabled; async clear drops all history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc <= '0;
    else if (en) acc <= acc + din;
  end

endmodule

// File: rtl/cic_interp.sv
// rtl/cic_interp.sv - N-stage CIC interpolator, ratio R, one output sample per clock
module cic_interp
  import cic_pkg::*;
#(
  parameter int Win  = CIC_WIN,
  parameter int N    = CIC_N,
  parameter int R    = CIC_R,
  parameter int Wg   = cic_guard_bits(CIC_N, CIC_R),
  parameter int Wout = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [Win-1:0]    i_data,
  input  logic                     val_in,
  output logic                     rdy_out,
  output logic                     val_out,
  output logic signed [Win+Wg-1:0] o_data,
  output logic signed [Wout-1:0]   o_data_trunc,
  output logic                     underflow
);

  localparam int W  = Win + Wg;
  localparam int PW = $clog2(R);

  cic_state_t          state;
  logic [PW-1:0]       ph;
  logic [PW-1:0]       ph_next;
  logic                slot;
  logic [W-1:0]        x;
  logic [N:0][W-1:0]   c;
  logic [N-1:0][W-1:0] d;
  logic [W-1:0]        creg;
  logic [W-1:0]        u;
  logic                run;
  logic [W-1:0]        stage_in  [N];
  logic [W-1:0]        stage_acc [N];

  // A slot is the IDLE->RUN transfer or any RUN cycle that offers rdy_out;
  // a missing sample in RUN is treated as zero rather than stalling the DAC path
  assign slot    = (state == IDLE) ? (rdy_out && val_in) : rdy_out;
  assign x       = val_in ? {{Wg{i_data[Win-1]}}, i_data} : '0;
  assign ph_next = ph + PW'(1);
  assign run     = (state == RUN);

  // Comb cascade at the low rate, M=1: each stage subtracts its previous-slot input
  always_comb begin
    c    = '0;
    c[0] = x;
    for (int k = 1; k <= N; k++) begin
      c[k] = c[k-1] - d[k-1];
    end
  end

  // Control FSM plus rate-gated comb delays and the comb output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ph        <= '0;
      rdy_out   <= 1'b0;
      val_out   <= 1'b0;
      underflow <= 1'b0;
      creg      <= '0;
      d         <= '0;
    end else begin
      if (slot) begin
        creg <= c[N];
        d    <= c[N-1:0];
      end
      case (state)
        IDLE: begin
          if (slot) begin
            state   <= RUN;
            ph      <= '0;
            rdy_out <= 1'b0;
            val_out <= 1'b1;
          end else begin
            rdy_out <= 1'b1;
          end
        end
        RUN: begin
          ph      <= ph_next;
          rdy_out <= (ph_next == PW'(R - 1));
          val_out <= 1'b1;
          if (rdy_out && !val_in) underflow <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-stuffing: the comb result enters the integrators once per R cycles
  assign u = (run && ph == '0) ? creg : '0;

  for (genvar k = 0; k < N; k++) begin : g_int
    if (k == 0) begin : g_first
      assign stage_in[k] = u;
    end else begin : g_rest
      assign stage_in[k] = stage_acc[k-1];
    end
    cic_int_stage #(.W(W)) u_int (
      .clk (clk),
      .rst (rst),
      .en  (run),
      .din (stage_in[k]),
      .acc (stage_acc[k])
    );
  end

  // Output register adds the final cycle of the fixed N+1 latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_data <= '0;
    else      o_data <= stage_acc[N-1];
  end

  assign o_data_trunc = o_data[W-1 -: Wout];

endmodule

// File: tb/tb_cic_interp.sv
// tb/tb_cic_interp.sv - scoreboard bench for the CIC interpolator
module tb_cic_interp;

  localparam int R    = 16;
  localparam int N    = 3;
  localparam int WIN  = 16;
  localparam int WG   = 8;
  localparam int W    = WIN + WG;
  localparam int WOUT = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic signed [WIN-1:0]  i_data;
  logic                   val_in;
  logic                   rdy_out;
  logic                   val_out;
  logic signed [W-1:0]    o_data;
  logic signed [WOUT-1:0] o_data_trunc;
  logic                   underflow;

  always #5 clk = ~clk;

  cic_interp #(.Win(WIN), .N(N), .R(R), .Wg(WG), .Wout(WOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .val_in       (val_in),
    .rdy_out      (rdy_out),
    .val_out      (val_out),
    .o_data       (o_data),
    .o_data_trunc (o_data_trunc),
    .underflow    (underflow)
  );

  int checks   = 0;
  int failures = 0;

  longint h [0:3*R-1];
  longint b2 [0:2*R-2];
  longint hist [3];
  longint exp_q [$];
  bit     running, idle_rdy, uf_m, want_start, sum_en;
  int     ph_m, slot_idx, drop_idx;
  longint first_val, rest_val, out_sum;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap_w(input longint v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return longint'(t);
  endfunction

  // New slot sample: compute the R outputs this slot period produces
  task automatic push_slot(input longint xv);
    longint e;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = xv;
    for (int j = 0; j < R; j++) begin
      e = hist[0] * h[j] + hist[1] * h[j+R] + hist[2] * h[j+2*R];
      exp_q.push_back(wrap_w(e));
    end
  endtask

  task automatic step();
    longint e, xv;
    @(negedge clk);
    check("val_out", val_out, running);
    check("rdy_out", rdy_out, running ? (ph_m == R - 1) : idle_rdy);
    check("underflow", underflow, uf_m);
    if (running) begin
      if (exp_q.size() == 0) begin
        check("q_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("o_data", o_data, e);
        check("o_trunc", o_data_trunc, e >>> WG);
        if (sum_en) out_sum += longint'(o_data);
      end
    end else begin
      check("o_idle", o_data, 0);
    end
    if (!running) begin
      if (idle_rdy && want_start) begin
        xv = first_val;
        val_in = 1'b1;
        i_data = WIN'(xv);
        running = 1'b1;
        ph_m = 0;
        slot_idx = 1;
        repeat (N + 1) exp_q.push_back(0);
        push_slot(xv);
      end else begin
        val_in = 1'b0;
        i_data = WIN'($urandom);
        idle_rdy = 1'b1;
      end
    end else begin
      if (ph_m == R - 1) begin
        if (slot_idx == drop_idx) begin
          val_in = 1'b0;
          i_data = WIN'($urandom);
          xv = 0;
          uf_m = 1'b1;
        end else begin
          xv = rest_val;
          val_in = 1'b1;
          i_data = WIN'(xv);
        end
        push_slot(xv);
        slot_idx++;
      end else begin
        val_in = 1'($urandom_range(0, 1));
        i_data = WIN'($urandom);
      end
      ph_m = (ph_m + 1) % R;
    end
  endtask

  task automatic do_reset(input string tag, input int hold);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check({tag, "_rst_rdy"}, rdy_out, 0);
    check({tag, "_rst_val"}, val_out, 0);
    check({tag, "_rst_uf"}, underflow, 0);
    check({tag, "_rst_data"}, o_data, 0);
    exp_q.delete();
    running = 1'b0;
    idle_rdy = 1'b0;
    uf_m = 1'b0;
    want_start = 1'b0;
    hist = '{0, 0, 0};
    ph_m = 0;
    val_in = 1'b0;
    repeat (hold) @(negedge clk);
    rst = 1'b1;
    idle_rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    val_in = 1'b0;
    i_data = '0;
    sum_en = 1'b0;
    out_sum = 0;
    drop_idx = -1;
    for (int i = 0; i < 2*R-1; i++) b2[i] = 0;
    for (int i = 0; i < 3*R; i++) h[i] = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) b2[i+j] += 1;
    for (int i = 0; i < 2*R-1; i++)
      for (int j = 0; j < R; j++) h[i+j] += b2[i];

    do_reset("por", 5);
    repeat (20) step();

    first_val = 1000; rest_val = 1000; drop_idx = -1; want_start = 1'b1;
    repeat (12*R) step();
    check("dc_full", o_data, 256000);
    check("dc_trunc", o_data_trunc, 1000);

    do_reset("mid_dc", 2);
    repeat (2) step();
    first_val = 256; rest_val = 0; drop_idx = -1; want_start = 1'b1;
    out_sum = 0; sum_en = 1'b1;
    repeat (8*R) step();
    sum_en = 1'b0;
    check("imp_sum", out_sum, 256*4096);

    do_reset("pre_fs", 2);
    repeat (2) step();
    first_val = -32768; rest_val = -32768; drop_idx = -1; want_start = 1'b1;
    repeat (12*R) step();
    check("fs_full", o_data, -8388608);
    check("fs_trunc", o_data_trunc, -32768);

    do_reset("pre_uf", 2);
    repeat (2) step();
    first_val = 500; rest_val = 500; drop_idx = 4; want_start = 1'b1;
    repeat (12*R) step();
    check("uf_sticky", underflow, 1);
    check("uf_trunc", o_data_trunc, 500);

    do_reset("final", 2);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
